// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM loop core: default widths, uop field layout, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gemm_pkg;

   localparam int DEF_BLOCK_IN  = 16;
   localparam int DEF_BLOCK_OUT = 16;
   localparam int DEF_INP_W     = 8;
   localparam int DEF_WGT_W     = 8;
   localparam int DEF_ACC_W     = 32;
   localparam int DEF_OUT_W     = 8;
   localparam int DEF_ACC_IDX_W = 11;
   localparam int DEF_INP_IDX_W = 11;
   localparam int DEF_WGT_IDX_W = 10;
   localparam int DEF_UPC_W     = 13;
   localparam int DEF_ITER_W    = 14;

   // A uop word is packed {wgt, inp, acc} with the acc index in the low bits.
   function automatic int uop_inp_lsb(input int acc_idx_w);
      return acc_idx_w;
   endfunction

   function automatic int uop_wgt_lsb(input int acc_idx_w, input int inp_idx_w);
      return acc_idx_w + inp_idx_w;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/gemm_mac_array.sv
// BLOCK_OUT x BLOCK_IN signed dot product added onto an accumulator vector.
// Latency: combinational.
// Backpressure: none.
// Ports: acc_in (BLOCK_OUT lanes of ACC_W), inp (BLOCK_IN of INP_W),
//        wgt (row j at [(j*BLOCK_IN+k)*WGT_W]), acc_out (wraps mod 2^ACC_W).
module gemm_mac_array
   import gemm_pkg::*;
#(
   parameter int BLOCK_IN  = DEF_BLOCK_IN,
   parameter int BLOCK_OUT = DEF_BLOCK_OUT,
   parameter int INP_W     = DEF_INP_W,
   parameter int WGT_W     = DEF_WGT_W,
   parameter int ACC_W     = DEF_ACC_W
) (
   input  logic [BLOCK_OUT*ACC_W-1:0]          acc_in,
   input  logic [BLOCK_IN*INP_W-1:0]           inp,
   input  logic [BLOCK_OUT*BLOCK_IN*WGT_W-1:0] wgt,
   output logic [BLOCK_OUT*ACC_W-1:0]          acc_out
);

   // Products are formed at full INP_W+WGT_W precision, then sign-extended
   // into the accumulator width so the running sum wraps naturally.
   localparam int PW = INP_W + WGT_W;

   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    b_ext;
   logic [PW-1:0]    prod;
   logic [ACC_W-1:0] sum;

   always_comb begin
      acc_out = '0;
      a_ext   = '0;
      b_ext   = '0;
      prod    = '0;
      sum     = '0;
      for (int j = 0; j < BLOCK_OUT; j++) begin
         sum = acc_in[j*ACC_W +: ACC_W];
         for (int k = 0; k < BLOCK_IN; k++) begin
            a_ext = {{(PW-INP_W){inp[k*INP_W+INP_W-1]}}, inp[k*INP_W +: INP_W]};
            b_ext = {{(PW-WGT_W){wgt[(j*BLOCK_IN+k)*WGT_W+WGT_W-1]}},
                     wgt[(j*BLOCK_IN+k)*WGT_W +: WGT_W]};
            prod  = a_ext * b_ext;
            sum   = sum + {{(ACC_W-PW){prod[PW-1]}}, prod};
         end
         acc_out[j*ACC_W +: ACC_W] = sum;
      end
   end

endmodule

// File: rtl/gemm_loop_core.sv
// GEMM core: runs iter_out x iter_in x uop loop nest for one instruction, one op per cycle.
// Latency: op issued at t writes at t+4; done pulses the cycle after the last write.
// Backpressure: insn_ready high only while idle; scratchpad ports never stall.
// Ports: insn_* decoded instruction handshake; uop/acc/inp/wgt read ports (1-cycle data);
//        acc/out write ports; done retirement pulse.
module gemm_loop_core
   import gemm_pkg::*;
#(
   parameter int BLOCK_IN  = DEF_BLOCK_IN,
   parameter int BLOCK_OUT = DEF_BLOCK_OUT,
   parameter int INP_W     = DEF_INP_W,
   parameter int WGT_W     = DEF_WGT_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int ACC_IDX_W = DEF_ACC_IDX_W,
   parameter int INP_IDX_W = DEF_INP_IDX_W,
   parameter int WGT_IDX_W = DEF_WGT_IDX_W,
   parameter int UPC_W     = DEF_UPC_W,
   parameter int ITER_W    = DEF_ITER_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 insn_valid,
   output logic                                 insn_ready,
   input  logic                                 insn_reset,
   input  logic [UPC_W-1:0]                     uop_bgn,
   input  logic [UPC_W-1:0]                     uop_end,
   input  logic [ITER_W-1:0]                    iter_out,
   input  logic [ITER_W-1:0]                    iter_in,
   input  logic [ACC_IDX_W-1:0]                 dst_fo,
   input  logic [ACC_IDX_W-1:0]                 dst_fi,
   input  logic [INP_IDX_W-1:0]                 src_fo,
   input  logic [INP_IDX_W-1:0]                 src_fi,
   input  logic [WGT_IDX_W-1:0]                 wgt_fo,
   input  logic [WGT_IDX_W-1:0]                 wgt_fi,
   output logic [UPC_W-1:0]                     uop_addr,
   input  logic [ACC_IDX_W+INP_IDX_W+WGT_IDX_W-1:0] uop_data,
   output logic [ACC_IDX_W-1:0]                 acc_rd_addr,
   input  logic [BLOCK_OUT*ACC_W-1:0]           acc_rd_data,
   output logic [INP_IDX_W-1:0]                 inp_rd_addr,
   input  logic [BLOCK_IN*INP_W-1:0]            inp_rd_data,
   output logic [WGT_IDX_W-1:0]                 wgt_rd_addr,
   input  logic [BLOCK_OUT*BLOCK_IN*WGT_W-1:0]  wgt_rd_data,
   output logic                                 acc_wr_en,
   output logic [ACC_IDX_W-1:0]                 acc_wr_addr,
   output logic [BLOCK_OUT*ACC_W-1:0]           acc_wr_data,
   output logic                                 out_wr_en,
   output logic [ACC_IDX_W-1:0]                 out_wr_addr,
   output logic [BLOCK_OUT*OUT_W-1:0]           out_wr_data,
   output logic                                 done
);

   localparam int INP_LSB = uop_inp_lsb(ACC_IDX_W);
   localparam int WGT_LSB = uop_wgt_lsb(ACC_IDX_W, INP_IDX_W);

   state_t               state;
   logic [UPC_W-1:0]     u_cnt, bgn_q, end_q;
   logic [ITER_W-1:0]    o_cnt, i_cnt, iout_q, iin_q;
   logic [ACC_IDX_W-1:0] dfo_q, dfi_q;
   logic [INP_IDX_W-1:0] sfo_q, sfi_q;
   logic [WGT_IDX_W-1:0] wfo_q, wfi_q;
   logic                 rmode_q;

   // Op pipeline: s1 uop data, s2 read addresses, s3 read data / MAC,
   // s4 write (W), s5 one-deep history of the previous write.
   logic                 s1_vld, s2_vld, s3_vld, s4_vld, s5_vld;
   logic [ITER_W-1:0]    s1_o, s1_i;
   logic [ACC_IDX_W-1:0] s2_acc, s3_dst, s4_addr, s5_addr;
   logic [INP_IDX_W-1:0] s2_inp;
   logic [WGT_IDX_W-1:0] s2_wgt;
   logic [BLOCK_OUT*ACC_W-1:0] s4_data, s5_data, acc_fwd, mac_res;

   logic [ACC_IDX_W-1:0] idx_acc;
   logic [INP_IDX_W-1:0] idx_inp;
   logic [WGT_IDX_W-1:0] idx_wgt;
   logic                 insn_empty;

   assign insn_empty = (iter_out == '0) || (iter_in == '0) || (uop_end <= uop_bgn);

   // Loop counters are truncated to index width before multiplying; only the
   // low bits survive the modulo anyway.
   assign idx_acc = uop_data[ACC_IDX_W-1:0]
                  + ACC_IDX_W'(s1_o) * dfo_q + ACC_IDX_W'(s1_i) * dfi_q;
   assign idx_inp = uop_data[INP_LSB +: INP_IDX_W]
                  + INP_IDX_W'(s1_o) * sfo_q + INP_IDX_W'(s1_i) * sfi_q;
   assign idx_wgt = uop_data[WGT_LSB +: WGT_IDX_W]
                  + WGT_IDX_W'(s1_o) * wfo_q + WGT_IDX_W'(s1_i) * wfi_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         insn_ready <= 1'b1;
         done       <= 1'b0;
         u_cnt      <= '0;
         o_cnt      <= '0;
         i_cnt      <= '0;
         bgn_q      <= '0;
         end_q      <= '0;
         iout_q     <= '0;
         iin_q      <= '0;
         dfo_q      <= '0;
         dfi_q      <= '0;
         sfo_q      <= '0;
         sfi_q      <= '0;
         wfo_q      <= '0;
         wfi_q      <= '0;
         rmode_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (insn_valid && insn_ready) begin
                  bgn_q      <= uop_bgn;
                  end_q      <= uop_end;
                  iout_q     <= iter_out;
                  iin_q      <= iter_in;
                  dfo_q      <= dst_fo;
                  dfi_q      <= dst_fi;
                  sfo_q      <= src_fo;
                  sfi_q      <= src_fi;
                  wfo_q      <= wgt_fo;
                  wfi_q      <= wgt_fi;
                  rmode_q    <= insn_reset;
                  u_cnt      <= uop_bgn;
                  o_cnt      <= '0;
                  i_cnt      <= '0;
                  insn_ready <= 1'b0;
                  if (insn_empty) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (u_cnt == end_q - UPC_W'(1)) begin
                  u_cnt <= bgn_q;
                  if (i_cnt == iin_q - ITER_W'(1)) begin
                     i_cnt <= '0;
                     if (o_cnt == iout_q - ITER_W'(1)) begin
                        o_cnt <= '0;
                        state <= S_DRAIN;
                     end else begin
                        o_cnt <= o_cnt + ITER_W'(1);
                     end
                  end else begin
                     i_cnt <= i_cnt + ITER_W'(1);
                  end
               end else begin
                  u_cnt <= u_cnt + UPC_W'(1);
               end
            end
            S_DRAIN: begin
               // The final op may still be in W this cycle; done follows it.
               if (!s1_vld && !s2_vld && !s3_vld) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               done       <= 1'b0;
               insn_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_o    <= '0;
         s1_i    <= '0;
         s2_vld  <= 1'b0;
         s2_acc  <= '0;
         s2_inp  <= '0;
         s2_wgt  <= '0;
         s3_vld  <= 1'b0;
         s3_dst  <= '0;
         s4_vld  <= 1'b0;
         s4_addr <= '0;
         s4_data <= '0;
         s5_vld  <= 1'b0;
         s5_addr <= '0;
         s5_data <= '0;
      end else begin
         s1_vld  <= (state == S_RUN);
         s1_o    <= o_cnt;
         s1_i    <= i_cnt;
         s2_vld  <= s1_vld;
         s2_acc  <= idx_acc;
         s2_inp  <= idx_inp;
         s2_wgt  <= idx_wgt;
         s3_vld  <= s2_vld;
         s3_dst  <= s2_acc;
         s4_vld  <= s3_vld;
         s4_addr <= s3_dst;
         s4_data <= rmode_q ? '0 : mac_res;
         s5_vld  <= s4_vld;
         s5_addr <= s4_addr;
         s5_data <= s4_data;
      end
   end

   // The SRAM read at t+2 misses writes landing at t+2 (op t-2) and t+3
   // (op t-1); patch those in, newest first.
   always_comb begin
      acc_fwd = acc_rd_data;
      if (s4_vld && (s4_addr == s3_dst)) begin
         acc_fwd = s4_data;
      end else if (s5_vld && (s5_addr == s3_dst)) begin
         acc_fwd = s5_data;
      end
   end

   gemm_mac_array #(
      .BLOCK_IN (BLOCK_IN),
      .BLOCK_OUT(BLOCK_OUT),
      .INP_W    (INP_W),
      .WGT_W    (WGT_W),
      .ACC_W    (ACC_W)
   ) u_mac (
      .acc_in (acc_fwd),
      .inp    (inp_rd_data),
      .wgt    (wgt_rd_data),
      .acc_out(mac_res)
   );

   assign uop_addr    = u_cnt;
   assign acc_rd_addr = s2_acc;
   assign inp_rd_addr = s2_inp;
   assign wgt_rd_addr = s2_wgt;
   assign acc_wr_en   = s4_vld;
   assign acc_wr_addr = s4_addr;
   assign acc_wr_data = s4_data;
   assign out_wr_en   = s4_vld && !rmode_q;
   assign out_wr_addr = s4_addr;

   for (genvar j = 0; j < BLOCK_OUT; j++) begin : g_out
      assign out_wr_data[j*OUT_W +: OUT_W] = s4_data[j*ACC_W +: OUT_W];
   end

endmodule

// File: tb/tb_gemm_loop_core.sv
module tb_gemm_loop_core;

   localparam int BI  = 16;
   localparam int BO  = 16;
   localparam int AW  = 32;
   localparam int OW  = 8;
   localparam int AIW = 11;
   localparam int IIW = 11;
   localparam int WIW = 10;
   localparam int UW  = 13;
   localparam int IW  = 14;
   localparam int UDW = AIW + IIW + WIW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic insn_valid = 1'b0, insn_ready, insn_reset = 1'b0;
   logic [UW-1:0]  uop_bgn = '0, uop_end = '0, uop_addr;
   logic [IW-1:0]  iter_out = '0, iter_in = '0;
   logic [AIW-1:0] dst_fo = '0, dst_fi = '0;
   logic [IIW-1:0] src_fo = '0, src_fi = '0;
   logic [WIW-1:0] wgt_fo = '0, wgt_fi = '0;
   logic [UDW-1:0] uop_data;
   logic [AIW-1:0] acc_rd_addr, acc_wr_addr, out_wr_addr;
   logic [IIW-1:0] inp_rd_addr;
   logic [WIW-1:0] wgt_rd_addr;
   logic [BO*AW-1:0]    acc_rd_data, acc_wr_data;
   logic [BI*8-1:0]     inp_rd_data;
   logic [BO*BI*8-1:0]  wgt_rd_data;
   logic [BO*OW-1:0]    out_wr_data;
   logic acc_wr_en, out_wr_en, done;

   int n_chk = 0;
   int n_err = 0;

   gemm_loop_core dut (
      .clk(clk), .rst(rst),
      .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_reset(insn_reset),
      .uop_bgn(uop_bgn), .uop_end(uop_end), .iter_out(iter_out), .iter_in(iter_in),
      .dst_fo(dst_fo), .dst_fi(dst_fi), .src_fo(src_fo), .src_fi(src_fi),
      .wgt_fo(wgt_fo), .wgt_fi(wgt_fi),
      .uop_addr(uop_addr), .uop_data(uop_data),
      .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
      .inp_rd_addr(inp_rd_addr), .inp_rd_data(inp_rd_data),
      .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
      .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
      .done(done)
   );

   always #5 clk = ~clk;

   // Scratchpad environment: 1-cycle read latency, read-before-write.
   logic [UDW-1:0]     uop_mem [0:8191];
   logic [BI*8-1:0]    inp_mem [0:2047];
   logic [BO*BI*8-1:0] wgt_mem [0:1023];
   logic [BO*AW-1:0]   acc_mem [0:2047];
   logic tb_we = 1'b0;
   logic [AIW-1:0]   tb_wa = '0;
   logic [BO*AW-1:0] tb_wd = '0;

   always @(posedge clk) begin
      uop_data    <= uop_mem[uop_addr];
      inp_rd_data <= inp_mem[inp_rd_addr];
      wgt_rd_data <= wgt_mem[wgt_rd_addr];
      acc_rd_data <= acc_mem[acc_rd_addr];
      if (acc_wr_en) acc_mem[acc_wr_addr] <= acc_wr_data;
      else if (tb_we) acc_mem[tb_wa] <= tb_wd;
   end

   // Reference accumulator image, updated op by op in loop order.
   logic [BO*AW-1:0] ref_acc [0:2047];

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [BO*AW-1:0] mac(input logic [BO*AW-1:0] a,
                                            input logic [BI*8-1:0] x,
                                            input logic [BO*BI*8-1:0] wt);
      logic [BO*AW-1:0] r;
      int s;
      r = '0;
      for (int j = 0; j < BO; j++) begin
         s = int'(a[j*AW +: AW]);
         for (int k = 0; k < BI; k++)
            s += int'($signed(x[k*8 +: 8])) * int'($signed(wt[(j*BI+k)*8 +: 8]));
         r[j*AW +: AW] = s;
      end
      return r;
   endfunction

   function automatic logic [BO*OW-1:0] low_bytes(input logic [BO*AW-1:0] v);
      logic [BO*OW-1:0] r;
      for (int j = 0; j < BO; j++) r[j*OW +: OW] = v[j*AW +: OW];
      return r;
   endfunction

   function automatic logic [BO*AW-1:0] rep32(input logic [31:0] v);
      logic [BO*AW-1:0] r;
      for (int j = 0; j < BO; j++) r[j*AW +: AW] = v;
      return r;
   endfunction

   function automatic logic [UDW-1:0] mk_uop(input int w, input int i, input int a);
      return {WIW'(w), IIW'(i), AIW'(a)};
   endfunction

   task automatic set_acc(input int a, input logic [BO*AW-1:0] v);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = AIW'(a); tb_wd = v;
      ref_acc[a] = v;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic init_acc(input bit zero);
      logic [BO*AW-1:0] v;
      for (int a = 0; a < 64; a++) begin
         v = '0;
         if (!zero) for (int j = 0; j < BO; j++) v[j*AW +: AW] = $urandom;
         @(negedge clk);
         tb_we = 1'b1; tb_wa = AIW'(a); tb_wd = v;
         ref_acc[a] = v;
      end
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic run_insn(input bit rm, input int bgn, input int en, input int io, input int ii,
                           input int dfo, input int dfi, input int sfo, input int sfi,
                           input int wfo, input int wfi);
      logic [AIW-1:0]   ea [$];
      logic [BO*AW-1:0] ed [$];
      logic [UDW-1:0]   u;
      logic [AIW-1:0]   d;
      logic [IIW-1:0]   s;
      logic [WIW-1:0]   g;
      logic [BO*AW-1:0] v;
      int n, cyc, nw, w;
      bit got_done;
      n = 0;
      for (int o = 0; o < io; o++)
         for (int i = 0; i < ii; i++)
            for (int x = bgn; x < en; x++) begin
               u = uop_mem[x];
               d = AIW'(int'(u[AIW-1:0]) + o*dfo + i*dfi);
               s = IIW'(int'(u[AIW +: IIW]) + o*sfo + i*sfi);
               g = WIW'(int'(u[AIW+IIW +: WIW]) + o*wfo + i*wfi);
               v = rm ? '0 : mac(ref_acc[d], inp_mem[s], wgt_mem[g]);
               ref_acc[d] = v;
               ea.push_back(d);
               ed.push_back(v);
               n++;
            end
      w = 0;
      while (!insn_ready && w < 100) begin @(negedge clk); w++; end
      chk("ready_before", insn_ready, 1);
      @(negedge clk);
      insn_valid = 1'b1; insn_reset = rm;
      uop_bgn = UW'(bgn); uop_end = UW'(en); iter_out = IW'(io); iter_in = IW'(ii);
      dst_fo = AIW'(dfo); dst_fi = AIW'(dfi); src_fo = IIW'(sfo); src_fi = IIW'(sfi);
      wgt_fo = WIW'(wfo); wgt_fi = WIW'(wfi);
      @(posedge clk); #1;
      insn_valid = 1'b0;
      cyc = 0; nw = 0; got_done = 1'b0;
      while (!got_done && cyc < n + 40) begin
         @(negedge clk);
         if (acc_wr_en) begin
            chk("wr_cycle", cyc, nw + 4);
            if (nw < n) begin
               chk("wr_addr", acc_wr_addr, ea[nw]);
               chk("wr_data", acc_wr_data, ed[nw]);
               chk("out_en", out_wr_en, !rm);
               if (!rm) begin
                  chk("out_addr", out_wr_addr, ea[nw]);
                  chk("out_data", out_wr_data, low_bytes(ed[nw]));
               end
            end else begin
               chk("extra_wr", 1, 0);
            end
            nw++;
         end else if (out_wr_en) begin
            chk("out_en_alone", 1, 0);
         end
         if (done) begin
            got_done = 1'b1;
            chk("done_cycle", cyc, (n == 0) ? 0 : n + 4);
         end
         cyc++;
      end
      chk("done_seen", got_done, 1);
      chk("wr_count", nw, n);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("ready_after", insn_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BI*8-1:0] iv;
      int b, l;
      for (int a = 0; a < 8192; a++) uop_mem[a] = '0;
      for (int a = 0; a < 2048; a++) begin inp_mem[a] = '0; ref_acc[a] = '0; acc_mem[a] = '0; end
      for (int a = 0; a < 1024; a++) wgt_mem[a] = '0;
      for (int a = 0; a < 128; a++) begin
         for (int q = 0; q < BI*8/32; q++) inp_mem[a][q*32 +: 32] = $urandom;
         for (int q = 0; q < BO*BI*8/32; q++) wgt_mem[a][q*32 +: 32] = $urandom;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", insn_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_acc_we", acc_wr_en, 0);
      chk("rst_out_we", out_wr_en, 0);
      chk("rst_uop_addr", uop_addr, 0);
      chk("rst_acc_wd", acc_wr_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single op: inp all 1, wgt all 2, acc 5 -> 37
      uop_mem[0] = mk_uop(0, 0, 3);
      inp_mem[0] = '0;
      for (int k = 0; k < BI; k++) inp_mem[0][k*8 +: 8] = 8'd1;
      for (int k = 0; k < BO*BI; k++) wgt_mem[0][k*8 +: 8] = 8'd2;
      set_acc(3, rep32(32'd5));
      run_insn(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("single_lane0", acc_mem[3][31:0], 37);
      chk("single_lane15", acc_mem[3][15*AW +: AW], 37);

      // 2x3 loop over 4 uops, dst factors 8/1
      for (int x = 0; x < 4; x++)
         uop_mem[x] = mk_uop($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 15));
      init_acc(0);
      run_insn(0, 0, 4, 2, 3, 8, 1, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));

      // Forwarding at distance 1 and 2: dot = 5*2 = 10 per lane
      inp_mem[40] = '0;
      inp_mem[40][7:0] = 8'd5;
      for (int k = 0; k < BO*BI; k++) wgt_mem[40][k*8 +: 8] = 8'd2;
      uop_mem[10] = mk_uop(40, 40, 5);
      uop_mem[11] = mk_uop(40, 40, 5);
      uop_mem[12] = mk_uop(40, 40, 5);
      uop_mem[13] = mk_uop(40, 40, 7);
      uop_mem[14] = mk_uop(40, 40, 8);
      uop_mem[15] = mk_uop(40, 40, 7);
      uop_mem[16] = mk_uop(40, 40, 8);
      init_acc(1);
      run_insn(0, 10, 17, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("fwd_d1_acc5", acc_mem[5][31:0], 30);
      chk("fwd_d2_acc7", acc_mem[7][9*AW +: AW], 20);
      chk("fwd_d2_acc8", acc_mem[8][31:0], 20);

      // Reset mode then GEMM on the same destinations
      for (int x = 0; x < 4; x++)
         uop_mem[20+x] = mk_uop($urandom_range(0, 63), $urandom_range(0, 63), 5 + 2*x);
      init_acc(0);
      run_insn(1, 20, 24, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("rmode_zero", acc_mem[9], 0);
      run_insn(0, 20, 24, 1, 1, 0, 0, 0, 0, 0, 0);

      // Empty instructions
      run_insn(0, 0, 4, 2, 0, 1, 1, 0, 0, 0, 0);
      run_insn(0, 3, 3, 2, 2, 1, 1, 0, 0, 0, 0);
      run_insn(0, 0, 4, 0, 2, 1, 1, 0, 0, 0, 0);

      // Random uop pool for the remaining tests
      for (int x = 30; x < 40; x++)
         uop_mem[x] = mk_uop($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 15));

      // Reset asserted mid-RUN
      @(negedge clk);
      insn_valid = 1'b1; insn_reset = 1'b0;
      uop_bgn = UW'(30); uop_end = UW'(34); iter_out = IW'(4); iter_in = IW'(4);
      dst_fo = AIW'(1); dst_fi = AIW'(2);
      @(posedge clk); #1;
      insn_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("abort_busy", acc_wr_en, 1);
      rst = 1'b1;
      #1;
      chk("abort_acc_we", acc_wr_en, 0);
      chk("abort_out_we", out_wr_en, 0);
      chk("abort_done", done, 0);
      chk("abort_ready", insn_ready, 1);
      chk("abort_uop_addr", uop_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      init_acc(0);
      run_insn(0, 30, 34, 2, 2, 1, 2, 1, 1, 1, 1);

      // Randomised instructions
      for (int t = 0; t < 8; t++) begin
         b = $urandom_range(30, 35);
         l = $urandom_range(0, 4);
         run_insn(($urandom_range(0, 4) == 0), b, b + l,
                  $urandom_range(0, 3), $urandom_range(1, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/gemm_loop_core.md
Name: gemm_loop_core

Overview:
- Parametrised GEMM execution core: accepts one decoded GEMM instruction per handshake and runs the full two-level loop nest (iter_out × iter_in × uop range) itself.
- Fetches micro-ops, computes acc/inp/wgt indices with per-loop factors, reads the three SRAM buffers and performs a BLOCK_OUT×BLOCK_IN int MAC per op.
- Writes results back to the accumulator and output buffers, with in-pipeline read-after-write forwarding.
- Sits between the instruction decoder and the acc/inp/wgt/out scratchpads; signals completion with a done pulse.

Parameters:
BLOCK_IN, 16, input vector length (dot-product depth)
BLOCK_OUT, 16, output lanes per op
INP_W, 8, input element width (signed)
WGT_W, 8, weight element width (signed)
ACC_W, 32, accumulator element width (signed)
OUT_W, 8, output element width (low bits of acc)
ACC_IDX_W, 11, acc/out buffer index width
INP_IDX_W, 11, inp buffer index width
WGT_IDX_W, 10, wgt buffer index width
UPC_W, 13, micro-op address width
ITER_W, 14, loop counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
insn_valid  in  1  instruction valid
insn_ready  out  1  core idle, may accept
insn_reset  in  1  reset mode: write zeros to acc
uop_bgn  in  UPC_W  first uop address
uop_end  in  UPC_W  one past last uop address
iter_out  in  ITER_W  outer loop count
iter_in  in  ITER_W  inner loop count
dst_fo, dst_fi  in  ACC_IDX_W  acc index factors (outer, inner)
src_fo, src_fi  in  INP_IDX_W  inp index factors
wgt_fo, wgt_fi  in  WGT_IDX_W  wgt index factors
uop_addr  out  UPC_W  uop memory read address
uop_data  in  ACC_IDX_W+INP_IDX_W+WGT_IDX_W  uop {wgt,inp,acc} read data, 1-cycle latency
acc_rd_addr  out  ACC_IDX_W  acc read address
acc_rd_data  in  BLOCK_OUT*ACC_W  acc read data, 1-cycle latency
inp_rd_addr  out  INP_IDX_W  inp read address
inp_rd_data  in  BLOCK_IN*INP_W  inp read data, 1-cycle latency
wgt_rd_addr  out  WGT_IDX_W  wgt read address
wgt_rd_data  in  BLOCK_OUT*BLOCK_IN*WGT_W  wgt read data, 1-cycle latency
acc_wr_en, acc_wr_addr, acc_wr_data  out  1/ACC_IDX_W/BLOCK_OUT*ACC_W  acc write port
out_wr_en, out_wr_addr, out_wr_data  out  1/ACC_IDX_W/BLOCK_OUT*OUT_W  out write port
done  out  1  one-cycle pulse when instruction fully retired

Behaviour:
- Reset (asynchronous, any time, incl. mid-instruction): FSM→IDLE, all counters and pipe valids cleared; insn_ready=1, done=0, all wr_en=0, all addresses/data=0. In-flight ops are dropped.
- FSM: IDLE --(insn_valid&insn_ready, operands latched)--> RUN; RUN --(last op issued)--> DRAIN; DRAIN --(pipe empty)--> DONE; DONE --(1 cycle, done=1)--> IDLE. insn_ready=1 only in IDLE.
- Empty instruction (iter_out==0, iter_in==0 or uop_end<=uop_bgn): IDLE→DONE directly, no writes.
- Loop order: outer o, inner i, then uop u from uop_bgn to uop_end-1; one op issued per cycle in RUN, no bubbles.
- Op pipeline (issue cycle t): t drive uop_addr; t+1 uop_data valid, indices = field + o*f_o + i*f_i, truncated mod 2^width and registered; t+2 rd addresses driven; t+3 read data valid, MAC computed; t+4 wr_en=1 with registered result.
- MAC: lane j = acc_j + Σ_k sext(inp_k)*sext(wgt_{j,k}), wrap-around mod 2^ACC_W. Weight row j at bits [(j*BLOCK_IN+k)*WGT_W +: WGT_W].
- Reset mode: acc_wr_data=0, out_wr_en=0, inp/wgt reads still issued (ignored).
- GEMM mode: acc_wr_en=out_wr_en=1; out lane = acc result lane [OUT_W-1:0]; same address on both ports.
- Forwarding: the acc value used at t+3 is taken from the op in W (issued t-1) if its dst matches, else from the 1-deep write-history register (issued t-2) if it matches, else acc_rd_data. Priority: newest first. Reset-mode writes forward as zero.
- done asserted exactly one cycle, after the last write's cycle.

Decomposition:
- Package gemm_pkg: widths, uop field offsets/slicing, FSM state encoding.
- Sub-module gemm_mac_array: combinational BLOCK_OUT×BLOCK_IN signed dot-product plus accumulate. The top level holds the FSM, loop counters, index pipeline and forwarding.

Test Plan:
- Single op, BLOCK 16, inp all 1, wgt all 2, acc 5 at idx 3 -> one write at t+4: acc lanes 37, out lanes 8'd37; done next cycle.
- uop_bgn=0, uop_end=4, iter_out=2, iter_in=3, factors dst 8/1 -> 24 consecutive writes; acc addrs follow o*8+i+uop.dst in loop order.
- Back-to-back ops on the same dst (distance 1 and 2), acc init 0, dot=10 -> final acc 30, proving both forwarding paths.
- Reset mode with iter 1×1, 4 uops -> four acc writes of 0, out_wr_en never high; a following GEMM sees forwarded zeros.
- iter_in=0 -> no wr_en, done 1 cycle after accept, insn_ready back high.
- rst asserted mid-RUN -> wr_en, done low immediately; insn_ready=1; a new instruction then executes correctly.
